// File: rtl/rom_reader_pkg.sv
// Shared types and latency-dependent constants for the ROM block reader.
// Build option ROM_LAT2_EN selects a 2-cycle (output-registered) ROM.
package rom_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

`ifdef ROM_LAT2_EN
  localparam int ROM_LAT    = 2;
  localparam int FIFO_DEPTH = 3;
`else
  localparam int ROM_LAT    = 1;
  localparam int FIFO_DEPTH = 2;
`endif

  localparam int TAG_DIM_W = 8;

  typedef struct packed {
    logic [TAG_DIM_W-1:0] x;
    logic [TAG_DIM_W-1:0] y;
    logic                 last;
  } tag_t;

  function automatic int unsigned ones(input logic [ROM_LAT-1:0] v);
    int unsigned n;
    n = 32'd0;
    for (int i = 0; i < ROM_LAT; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

  // A new read is allowed only if every word already owed to the FIFO still fits after it.
  function automatic logic credit_ok(input int unsigned count, input int unsigned inflight,
                                     input logic pop);
    int unsigned room;
    room = FIFO_DEPTH - 1;
    if (pop) begin
      room = room + 32'd1;
    end else begin
      room = room;
    end
    return (count + inflight) <= room;
  endfunction

endpackage

// File: rtl/rom_rd_fifo.sv
// Small circular FIFO holding {ROM word, tag} pairs between the ROM and the stream port.
// Head entry is presented continuously; pop on an empty FIFO is ignored.
module rom_rd_fifo
  import rom_reader_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  tag_t              push_tag,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output tag_t              head_tag,
  output logic [CNT_W-1:0]  count,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_data_r [DEPTH];
  tag_t              mem_tag_r  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              pop_s;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop_s     = pop && (count_r != '0);
  assign empty     = (count_r == '0);
  assign count     = count_r;
  assign head_data = mem_data_r[rd_ptr_r];
  assign head_tag  = mem_tag_r[rd_ptr_r];

  // Storage, pointers and occupancy; entries are cleared on reset so outputs read zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data_r[i] <= '0;
        mem_tag_r[i]  <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        mem_data_r[wr_ptr_r] <= push_data;
        mem_tag_r[wr_ptr_r]  <= push_tag;
        wr_ptr_r             <= next_ptr(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({push, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/rom_block_reader.sv
// Fetches a width x height rectangle from a synchronous ROM and streams it with x/y tags.
// Build option ROM_LAT2_EN: 2-cycle ROM, deeper tag pipe and FIFO (see rom_reader_pkg).
module rom_block_reader
  import rom_reader_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 256,
  parameter  int DIM_W  = TAG_DIM_W,
  localparam int ADDRW  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDRW-1:0]  base_addr,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  height,
  input  logic [DIM_W-1:0]  stride,
  output logic              busy,
  output logic              done,
  output logic [ADDRW-1:0]  rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [DIM_W-1:0]  out_x,
  output logic [DIM_W-1:0]  out_y,
  output logic              out_last
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  state_t             state_r, state_s;
  logic [DIM_W-1:0]   width_r, height_r, stride_r, x_r, y_r;
  logic [ADDRW-1:0]   row_base_r, addr_r, issue_addr_s;
  logic               busy_r, done_r;
  logic [ROM_LAT-1:0] pipe_vld_r;
  tag_t               pipe_tag_r [ROM_LAT];
  logic               issue_s, pop_s, last_issue_s, zero_job_s, row_end_s;
  tag_t               head_tag_s;
  logic [CNT_W-1:0]   fifo_count_s;
  logic               fifo_empty_s;

  assign zero_job_s   = (width == '0) || (height == '0);
  assign row_end_s    = (x_r == width_r - 1'b1);
  assign last_issue_s = row_end_s && (y_r == height_r - 1'b1);
  assign issue_addr_s = row_base_r + ADDRW'(x_r);
  assign pop_s        = out_valid && out_ready;

  // The ROM registers its address on the issuing edge, so the new address is presented
  // combinationally in the issue cycle; otherwise the last issued address is held.
  assign rom_addr = issue_s ? issue_addr_s : addr_r;

  // Next-state and issue decision.
  always_comb begin
    state_s = state_r;
    issue_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && !zero_job_s) state_s = RUN;
        else                      state_s = IDLE;
      end
      RUN: begin
        issue_s = credit_ok(32'(fifo_count_s), ones(pipe_vld_r), pop_s);
        if (issue_s && last_issue_s) state_s = DRAIN;
        else                         state_s = RUN;
      end
      DRAIN: begin
        if (pop_s && head_tag_s.last) state_s = IDLE;
        else                          state_s = DRAIN;
      end
      default: state_s = IDLE;
    endcase
  end

  // Job registers, raster counters and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      width_r    <= '0;
      height_r   <= '0;
      stride_r   <= '0;
      x_r        <= '0;
      y_r        <= '0;
      row_base_r <= '0;
      addr_r     <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r <= state_s;
      done_r  <= 1'b0;
      if ((state_r == IDLE) && start) begin
        width_r    <= width;
        height_r   <= height;
        stride_r   <= stride;
        row_base_r <= base_addr;
        x_r        <= '0;
        y_r        <= '0;
        busy_r     <= !zero_job_s;
        done_r     <= zero_job_s;
      end else if ((state_r == DRAIN) && (state_s == IDLE)) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end
      if (issue_s) begin
        addr_r <= issue_addr_s;
        if (row_end_s) begin
          x_r        <= '0;
          y_r        <= y_r + 1'b1;
          row_base_r <= row_base_r + ADDRW'(stride_r);
        end else begin
          x_r <= x_r + 1'b1;
        end
      end
    end
  end

  // Tag pipe tracking each read until its word appears on rom_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_r <= '0;
      for (int i = 0; i < ROM_LAT; i++) pipe_tag_r[i] <= '0;
    end else begin
      pipe_vld_r[0] <= issue_s;
      pipe_tag_r[0] <= '{x: x_r, y: y_r, last: last_issue_s};
      for (int i = 1; i < ROM_LAT; i++) begin
        pipe_vld_r[i] <= pipe_vld_r[i-1];
        pipe_tag_r[i] <= pipe_tag_r[i-1];
      end
    end
  end

  rom_rd_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pipe_vld_r[ROM_LAT-1]),
    .push_data (rom_data),
    .push_tag  (pipe_tag_r[ROM_LAT-1]),
    .pop       (pop_s),
    .head_data (out_data),
    .head_tag  (head_tag_s),
    .count     (fifo_count_s),
    .empty     (fifo_empty_s)
  );

  assign out_valid = !fifo_empty_s;
  assign out_x     = head_tag_s.x;
  assign out_y     = head_tag_s.y;
  assign out_last  = head_tag_s.last;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_rom_block_reader.sv
// Self-checking bench for rom_block_reader: job table + scoreboard of expected stream elements,
// plus hand-written sequences for zero-size jobs, ignored restart and mid-job reset.
module tb_rom_block_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] base_addr, width, height, stride;
  logic       busy, done;
  logic [7:0] rom_addr, rom_data;
  logic       out_valid, out_ready;
  logic [7:0] out_data, out_x, out_y;
  logic       out_last;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rom_block_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .width     (width),
    .height    (height),
    .stride    (stride),
    .busy      (busy),
    .done      (done),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_last  (out_last)
  );

  function automatic logic [7:0] rom_img(input logic [7:0] a);
    return a * 8'd7 + 8'd3;
  endfunction

`ifdef ROM_LAT2_EN
  logic [7:0] rom_q;
  always @(posedge clk) begin
    rom_q    <= rom_img(rom_addr);
    rom_data <= rom_q;
  end
`else
  always @(posedge clk) rom_data <= rom_img(rom_addr);
`endif

  typedef struct {
    logic [7:0] data;
    logic [7:0] x;
    logic [7:0] y;
    logic       last;
  } elt_t;

  typedef struct {
    logic [7:0] base;
    logic [7:0] w;
    logic [7:0] h;
    logic [7:0] stride;
    bit         toggle;
    int         exp_n;
    logic [7:0] exp_last_addr;
  } job_t;

  elt_t       sb[$];
  job_t       jobs[5];
  bit         expect_done = 1'b0;
  int         pops = 0;
  logic [7:0] last_pop_data = 8'd0;
  bit         prev_stall = 1'b0;
  logic [24:0] prev_word = 25'd0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: pops against scoreboard, done timing, stability under backpressure.
  initial begin
    elt_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall  = 1'b0;
        expect_done = 1'b0;
      end else begin
        if (expect_done) begin
          check("done_pulse", {30'd0, done, busy}, 32'h2);
          expect_done = 1'b0;
        end else if (done) begin
          check("spurious_done", {31'd0, done}, 32'd0);
        end
        if (prev_stall) begin
          check("stall_hold", {6'd0, out_valid, out_data, out_x, out_y, out_last},
                {6'd0, 1'b1, prev_word});
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_pop", {24'd0, out_data}, 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            check("elem", {7'd0, out_data, out_x, out_y, out_last},
                  {7'd0, e.data, e.x, e.y, e.last});
            pops++;
            last_pop_data = out_data;
            if (e.last) expect_done = 1'b1;
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_word  = {out_data, out_x, out_y, out_last};
      end
    end
  end

  task automatic load_sb(input job_t j);
    int t;
    elt_t e;
    for (int yy = 0; yy < int'(j.h); yy++) begin
      for (int xx = 0; xx < int'(j.w); xx++) begin
        t      = int'(j.base) + yy * int'(j.stride) + xx;
        e.data = rom_img(t[7:0]);
        e.x    = xx[7:0];
        e.y    = yy[7:0];
        e.last = (xx == int'(j.w) - 1) && (yy == int'(j.h) - 1);
        sb.push_back(e);
      end
    end
  endtask

  task automatic drive_start(input job_t j);
    @(posedge clk); #1;
    base_addr = j.base;
    width     = j.w;
    height    = j.h;
    stride    = j.stride;
    start     = 1'b1;
  endtask

  task automatic run_job(input job_t j, input bit repulse);
    bit ok = 1'b0;
    pops = 0;
    load_sb(j);
    out_ready = 1'b1;
    drive_start(j);
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      out_ready = j.toggle ? ~out_ready : 1'b1;
      if (repulse && c == 2) begin
        base_addr = 8'h40; width = 8'd2; height = 8'd2; stride = 8'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (sb.size() == 0 && !busy && !expect_done && c > 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("job_timeout", {31'd0, ok}, 32'd1);
    check("pop_count", pops, j.exp_n);
    check("last_data", {24'd0, last_pop_data}, {24'd0, rom_img(j.exp_last_addr)});
    sb.delete();
    out_ready = 1'b1;
  endtask

  initial begin
    job_t z;
    logic [7:0] held;
    jobs[0] = '{8'h10, 8'd4, 8'd2, 8'd16,  1'b0, 8, 8'h23};
    jobs[1] = '{8'h10, 8'd4, 8'd2, 8'd16,  1'b1, 8, 8'h23};
    jobs[2] = '{8'hFE, 8'd4, 8'd1, 8'd0,   1'b0, 4, 8'h01};
    jobs[3] = '{8'h05, 8'd3, 8'd3, 8'hFD,  1'b1, 9, 8'h01};
    jobs[4] = '{8'h80, 8'd1, 8'd1, 8'd7,   1'b0, 1, 8'h80};

    rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
    base_addr = 8'd0; width = 8'd0; height = 8'd0; stride = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {busy, done, out_valid, out_last, rom_addr, out_data, out_x, out_y}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_job(jobs[i], 1'b0);

    // Zero-size job: done next cycle, nothing else moves.
    held = rom_addr;
    z = '{8'h33, 8'd0, 8'd5, 8'd1, 1'b0, 0, 8'h00};
    drive_start(z);
    @(posedge clk); #1;
    start = 1'b0;
    expect_done = 1'b1;
    for (int c = 0; c < 4; c++) begin
      check("zero_job_quiet", {busy, out_valid, rom_addr}, {2'b00, held});
      @(posedge clk); #1;
    end
    check("zero_job_done_seen", {31'd0, expect_done}, 32'd0);

    // Restart pulse mid-job is ignored.
    run_job(jobs[0], 1'b1);

    // Reset while the FIFO holds data.
    load_sb(jobs[0]);
    out_ready = 1'b0;
    drive_start(jobs[0]);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("pre_reset_valid", {busy, out_valid}, 32'd3);
    rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", {busy, done, out_valid, out_last, rom_addr, out_data, out_x, out_y}, 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    run_job(jobs[2], 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
